// File: rtl/conv2d_stream_mc.sv
// conv2d_stream_mc: streaming KxK valid-padding, stride-1 convolution producing N_FILT serialised outputs per window.
// Optional feature macro CONV_RELU_EN: clamp negative saturated results to zero.

module conv2d_stream_mc_lane #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 5,
  parameter int K      = 5,
  parameter int ACC_W  = 21
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [K*K-1:0][DATA_W-1:0] i_taps,
  input  logic [K*K-1:0][DATA_W-1:0] i_wts,
  input  logic [DATA_W-1:0]          i_bias,
  output logic [DATA_W-1:0]          o_res
);
  localparam int PW = 2*DATA_W;
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(1 << (DATA_W-1)));

  logic signed [PW-1:0]     r_prod [K*K];
  logic signed [ACC_W-1:0]  r_row  [K];
  logic signed [ACC_W-1:0]  r_sum;
  logic signed [ACC_W-1:0]  w_row  [K];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W:0]    w_shf;
  logic        [DATA_W-1:0] w_sat;
  logic        [DATA_W-1:0] w_res;

  // Two-level adder tree: per-kernel-row sums, then the sum of rows.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      w_row[r] = '0;
      for (int c = 0; c < K; c++) w_row[r] = w_row[r] + ACC_W'(r_prod[r*K+c]);
    end
    w_sum = '0;
    for (int r = 0; r < K; r++) w_sum = w_sum + r_row[r];
    w_shf = ((ACC_W+1)'(r_sum) + ((ACC_W+1)'($signed(i_bias)) <<< FRAC_W)) >>> FRAC_W;
    if (w_shf > SAT_HI)      w_sat = SAT_HI[DATA_W-1:0];
    else if (w_shf < SAT_LO) w_sat = SAT_LO[DATA_W-1:0];
    else                     w_sat = w_shf[DATA_W-1:0];
  end

`ifdef CONV_RELU_EN
  assign w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < K*K; i++) r_prod[i] <= '0;
      for (int r = 0; r < K; r++)   r_row[r]  <= '0;
      r_sum <= '0;
      o_res <= '0;
    end else begin
      for (int i = 0; i < K*K; i++) r_prod[i] <= PW'($signed(i_taps[i])) * PW'($signed(i_wts[i]));
      for (int r = 0; r < K; r++)   r_row[r]  <= w_row[r];
      r_sum <= w_sum;
      o_res <= w_res;
    end
  end
endmodule

module conv2d_stream_mc #(
  parameter int DATA_W     = 8,
  parameter int FRAC_W     = 5,
  parameter int IN_W       = 16,
  parameter int IN_H       = 16,
  parameter int K          = 5,
  parameter int N_FILT     = 4,
  parameter int OBUF_DEPTH = 4,
  parameter logic [N_FILT*K*K*DATA_W-1:0] WEIGHTS = '0,
  parameter logic [N_FILT*DATA_W-1:0]     BIASES  = '0
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  input  logic [DATA_W-1:0] in_dout,
  input  logic              in_empty_n,
  output logic              in_read,
  output logic [DATA_W-1:0] out_din,
  input  logic              out_full_n,
  output logic              out_write
);
  localparam int ACC_W  = 2*DATA_W + $clog2(K*K);
  localparam int SR_LEN = (K-1)*IN_W + K-1;
  localparam int CW     = $clog2(IN_W);
  localparam int RW     = $clog2(IN_H);
  localparam int PTR_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OBUF_DEPTH+1);
  localparam int FI_W   = (N_FILT > 1) ? $clog2(N_FILT) : 1;
  localparam int STAGES = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                                        r_state;
  logic [CW-1:0]                                 r_col;
  logic [RW-1:0]                                 r_row;
  logic [SR_LEN-1:0][DATA_W-1:0]                 r_sr;
  logic [STAGES:1]                               r_vld_pipe;
  logic [OBUF_DEPTH-1:0][N_FILT-1:0][DATA_W-1:0] r_buf;
  logic [PTR_W-1:0]                              r_wp, r_rp;
  logic [CNT_W-1:0]                              r_cnt, r_credits;
  logic [FI_W-1:0]                               r_fidx;
  logic [K*K-1:0][DATA_W-1:0]                    w_taps;
  logic [N_FILT-1:0][DATA_W-1:0]                 w_res;
  logic w_win, w_last_px, w_issue, w_push, w_pop;

  assign w_win     = (r_row >= RW'(K-1)) && (r_col >= CW'(K-1));
  assign w_last_px = (r_row == RW'(IN_H-1)) && (r_col == CW'(IN_W-1));
  assign in_read   = (r_state == S_RUN) && in_empty_n && (!w_win || (r_credits != '0));
  assign w_issue   = in_read && w_win;
  assign w_push    = r_vld_pipe[STAGES];
  assign out_write = (r_cnt != '0) && out_full_n;
  assign w_pop     = out_write && (r_fidx == FI_W'(N_FILT-1));
  assign out_din   = r_buf[r_rp][r_fidx];
  assign ap_idle   = (r_state == S_IDLE);
  assign ap_ready  = in_read && w_last_px;
  assign ap_done   = (r_state == S_DRAIN) && w_pop && (r_cnt == CNT_W'(1)) && !(|r_vld_pipe);

  // Flat shift register holds K-1 full rows plus the window; the newest tap is the pixel being read.
  for (genvar r = 0; r < K; r++) begin : g_tr
    for (genvar c = 0; c < K; c++) begin : g_tc
      localparam int D = (K-1-r)*IN_W + (K-1-c);
      if (D == 0) begin : g_new
        assign w_taps[r*K+c] = in_dout;
      end else begin : g_old
        assign w_taps[r*K+c] = r_sr[D-1];
      end
    end
  end

  for (genvar f = 0; f < N_FILT; f++) begin : g_lane
    conv2d_stream_mc_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .K(K), .ACC_W(ACC_W)) u_lane (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .i_taps  (w_taps),
      .i_wts   (WEIGHTS[f*K*K*DATA_W +: K*K*DATA_W]),
      .i_bias  (BIASES[f*DATA_W +: DATA_W]),
      .o_res   (w_res[f])
    );
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_sr       <= '0;
      r_vld_pipe <= '0;
      r_buf      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_credits  <= CNT_W'(OBUF_DEPTH);
      r_fidx     <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (ap_start) r_state <= S_RUN;
        S_RUN:   if (ap_ready) r_state <= S_DRAIN;
        S_DRAIN: if (ap_done)  r_state <= S_DONE;
        S_DONE:  r_state <= ap_start ? S_RUN : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (in_read) begin
        r_sr <= {r_sr[SR_LEN-2:0], in_dout};
        if (r_col == CW'(IN_W-1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IN_H-1)) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_issue};
      // Credits cover windows in flight as well as buffered, so a push always has room.
      r_credits  <= r_credits - CNT_W'(w_issue) + CNT_W'(w_pop);
      r_cnt      <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_buf[r_wp] <= w_res;
        r_wp <= (r_wp == PTR_W'(OBUF_DEPTH-1)) ? '0 : r_wp + PTR_W'(1);
      end
      if (out_write) r_fidx <= w_pop ? '0 : r_fidx + FI_W'(1);
      if (w_pop) r_rp <= (r_rp == PTR_W'(OBUF_DEPTH-1)) ? '0 : r_rp + PTR_W'(1);
    end
  end
endmodule

// File: tb/tb_conv2d_stream_mc.sv
// tb_conv2d_stream_mc: random frames against an arithmetic conv reference; covers latency, backpressure, reset, back-to-back.
module tb_conv2d_stream_mc;
  localparam int IW = 6, IH = 6, KS = 3, NF = 2, FR = 5, KK = KS*KS, NPIX = IW*IH;
  localparam int NOUT = (IW-KS+1)*(IH-KS+1)*NF;

  function automatic int wt(input int f, input int i);
    return (f == 0) ? 8 + 4*i : -32 + 3*i;
  endfunction
  function automatic int bs(input int f);
    return (f == 0) ? 16 : -16;
  endfunction
  function automatic logic [NF*KK*8-1:0] mk_wts();
    logic [NF*KK*8-1:0] v;
    v = '0;
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < KK; i++) v[(f*KK+i)*8 +: 8] = 8'(wt(f, i));
    return v;
  endfunction
  function automatic logic [NF*8-1:0] mk_bias();
    logic [NF*8-1:0] v;
    v = '0;
    for (int f = 0; f < NF; f++) v[f*8 +: 8] = 8'(bs(f));
    return v;
  endfunction
  localparam logic [NF*KK*8-1:0] WTS  = mk_wts();
  localparam logic [NF*8-1:0]    BIAS = mk_bias();

  logic       ap_clk, ap_rst_n, ap_start, ap_done, ap_ready, ap_idle;
  logic [7:0] in_dout, out_din;
  logic       in_empty_n, in_read, out_full_n, out_write;

  conv2d_stream_mc #(.DATA_W(8), .FRAC_W(FR), .IN_W(IW), .IN_H(IH), .K(KS), .N_FILT(NF),
                     .OBUF_DEPTH(4), .WEIGHTS(WTS), .BIASES(BIAS)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .in_dout(in_dout), .in_empty_n(in_empty_n),
    .in_read(in_read), .out_din(out_din), .out_full_n(out_full_n), .out_write(out_write));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_vec, n_bad;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int img[NPIX];
  int gap_pct, full_pct;
  bit bp_hold;

  // Reference: direct sum over each valid window, then bias, floor-shift, saturate.
  task automatic load_frame(input int kind);
    int acc;
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       img[i] = 4;
        1:       img[i] = 127;
        3:       img[i] = -128;
        default: img[i] = int'($signed(8'($urandom_range(255))));
      endcase
      src_q.push_back(8'(img[i]));
    end
    for (int wr = 0; wr <= IH-KS; wr++)
      for (int wc = 0; wc <= IW-KS; wc++)
        for (int f = 0; f < NF; f++) begin
          acc = 0;
          for (int r = 0; r < KS; r++)
            for (int c = 0; c < KS; c++) acc += img[(wr+r)*IW + wc + c] * wt(f, r*KS+c);
          acc = (acc + bs(f) * (1 << FR)) >>> FR;
          if (acc > 127) acc = 127;
          else if (acc < -128) acc = -128;
`ifdef CONV_RELU_EN
          if (acc < 0) acc = 0;
`endif
          exp_q.push_back(8'(acc));
        end
  endtask

  initial begin
    in_empty_n = 1'b0;
    in_dout    = '0;
    forever begin
      @(posedge ap_clk); #1;
      if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_empty_n = 1'b1;
        in_dout    = src_q[0];
      end else begin
        in_empty_n = 1'b0;
        in_dout    = '0;
      end
    end
  end

  initial begin
    out_full_n = 1'b1;
    forever begin
      @(posedge ap_clk); #1;
      out_full_n = bp_hold ? 1'b0 : ($urandom_range(99) >= full_pct);
    end
  end

  int cyc, px_idx, wr_fr, n_rd, n_wr, n_done, n_ready, n_idle, win_iss;
  int t_px14, t_first_wr, t_done, last_gap, wr_at_done;
  initial begin
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (!ap_rst_n) begin
        px_idx = 0; wr_fr = 0; win_iss = 0; n_wr = 0;
        src_q.delete();
        exp_q.delete();
      end else begin
        if (ap_idle) n_idle++;
        if (in_read) begin
          if (px_idx == 0)  last_gap = cyc - t_done;
          if (px_idx == 14) t_px14 = cyc;
          if (px_idx / IW >= KS-1 && px_idx % IW >= KS-1) win_iss++;
          if (src_q.size() > 0) void'(src_q.pop_front());
          n_rd++;
          px_idx = (px_idx == NPIX-1) ? 0 : px_idx + 1;
        end
        if (ap_ready) n_ready++;
        if (out_write) begin
          if (wr_fr == 0) t_first_wr = cyc;
          wr_fr++;
          n_wr++;
          if (exp_q.size() == 0) chk("spurious_wr", 1, 0);
          else chk("dout", out_din, exp_q.pop_front());
        end
        if (ap_done) begin
          n_done++;
          t_done = cyc;
          wr_at_done = wr_fr;
          wr_fr = 0;
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 3000) begin @(posedge ap_clk); t++; end
    chk("done_timeout", 32'(n_done >= target), 1);
  endtask

  task automatic wait_px(input int n);
    int t = 0;
    while (px_idx < n && t < 2000) begin @(posedge ap_clk); t++; end
    chk("px_timeout", 32'(px_idx >= n), 1);
  endtask

  task automatic start_pulse();
    @(posedge ap_clk); #1 ap_start = 1'b1;
    @(posedge ap_clk); #1 ap_start = 1'b0;
  endtask

  task automatic frame_end(input int d0, input int r0);
    wait_done(d0 + 1);
    repeat (3) @(posedge ap_clk);
    chk("done_cnt",  n_done - d0, 1);
    chk("ready_cnt", n_ready - r0, 1);
    chk("done_wr",   wr_at_done, NOUT);
    chk("exp_left",  exp_q.size(), 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_idle",  ap_idle, 1);
    chk("rst_done",  ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_read",  in_read, 0);
    chk("rst_write", out_write, 0);
  endtask

  initial begin
    int d0, r0, i0, i1, n0;
    ap_rst_n = 1'b0; ap_start = 1'b0;
    gap_pct = 0; full_pct = 0; bp_hold = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk_reset_outs();
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;

    load_frame(0);
    repeat (5) @(posedge ap_clk);
    chk("idle_noread", n_rd, 0);
    d0 = n_done; r0 = n_ready;
    start_pulse();
    frame_end(d0, r0);
    chk("latency", t_first_wr - t_px14, 5);

    for (int k = 1; k <= 3; k += 2) begin
      load_frame(k);
      d0 = n_done; r0 = n_ready;
      start_pulse();
      frame_end(d0, r0);
    end

    gap_pct = 25; full_pct = 30;
    for (int k = 0; k < 3; k++) begin
      load_frame(2);
      d0 = n_done; r0 = n_ready;
      start_pulse();
      frame_end(d0, r0);
    end

    gap_pct = 0; full_pct = 0;
    load_frame(2);
    d0 = n_done; r0 = n_ready;
    start_pulse();
    wait_px(16);
    bp_hold = 1'b1;
    repeat (20) @(posedge ap_clk);
    n0 = n_rd;
    for (int k = 0; k < 20; k++) begin
      @(negedge ap_clk);
      chk("bp_hold", out_din, exp_q[0]);
    end
    chk("bp_rd_stop", n_rd - n0, 0);
    chk("bp_pend", win_iss - n_wr / NF, 4);
    bp_hold = 1'b0;
    frame_end(d0, r0);

    full_pct = 30;
    load_frame(2);
    start_pulse();
    wait_px(21);
    @(posedge ap_clk); #2 ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk_reset_outs();
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (10) @(posedge ap_clk);
    chk("rst_nowr", n_wr, 0);
    load_frame(2);
    d0 = n_done; r0 = n_ready;
    start_pulse();
    frame_end(d0, r0);

    full_pct = 0;
    load_frame(2);
    load_frame(2);
    d0 = n_done; r0 = n_ready;
    @(posedge ap_clk); #1 ap_start = 1'b1;
    repeat (2) @(posedge ap_clk);
    i0 = n_idle;
    wait_done(d0 + 1);
    @(posedge ap_clk); #1 ap_start = 1'b0;
    wait_done(d0 + 2);
    i1 = n_idle;
    repeat (3) @(posedge ap_clk);
    chk("b2b_done",  n_done - d0, 2);
    chk("b2b_ready", n_ready - r0, 2);
    chk("b2b_gap",   last_gap, 2);
    chk("b2b_idle",  i1 - i0, 0);
    chk("b2b_left",  exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
